// File: rtl/dmem_mmio_if.sv
// Core data-port bus plus the TX byte stream of the dmem/MMIO subsystem.
// master = core/consumer side, slave = memory subsystem side.
interface dmem_mmio_if #(
  parameter int WIDTH = 32,
  parameter int DADDR = 16
);
  logic [DADDR-1:0] dmem_addr;
  logic [WIDTH-1:0] dmem_wdata;
  logic [3:0]       dmem_wr_en;
  logic [WIDTH-1:0] dmem_rdata;
  logic [7:0]       tx_data;
  logic             tx_valid;
  logic             tx_ready;

  modport master (
    output dmem_addr, dmem_wdata, dmem_wr_en, tx_ready,
    input  dmem_rdata, tx_data, tx_valid
  );

  modport slave (
    input  dmem_addr, dmem_wdata, dmem_wr_en, tx_ready,
    output dmem_rdata, tx_data, tx_valid
  );
endinterface

// File: rtl/dmem_mmio.sv
// Data-side memory subsystem: byte-writable RAM plus an MMIO window holding
// a free-running 64-bit cycle counter and a byte TX FIFO with valid/ready drain.
module dmem_mmio #(
  parameter int WIDTH   = 32,
  parameter int DADDR   = 16,
  parameter int RAM_AW  = 12,
  parameter int FIFO_AW = 3
) (
  input logic        clk,
  input logic        reset,
  dmem_mmio_if.slave bus
);
  localparam int RAM_DEPTH  = 2**RAM_AW;
  localparam int FIFO_DEPTH = 2**FIFO_AW;
  localparam logic [FIFO_AW:0] FULL_COUNT = (FIFO_AW+1)'(FIFO_DEPTH);
  localparam logic [FIFO_AW:0] ZERO_COUNT = {(FIFO_AW+1){1'b0}};

  typedef enum logic [1:0] {
    REG_CYCLE_LO = 2'd0,
    REG_CYCLE_HI = 2'd1,
    REG_TX_DATA  = 2'd2,
    REG_STATUS   = 2'd3
  } mmio_reg_e;

  logic [WIDTH-1:0]   ram_r [RAM_DEPTH];
  logic [7:0]         fifo_r [FIFO_DEPTH];
  logic [63:0]        cycle_r;
  logic [FIFO_AW-1:0] rd_ptr_r;
  logic [FIFO_AW-1:0] wr_ptr_r;
  logic [FIFO_AW:0]   count_r;
  logic               overflow_r;

  logic              mmio_sel_s;
  mmio_reg_e         reg_sel_s;
  logic [RAM_AW-1:0] ram_idx_s;
  logic              push_req_s;
  logic              push_ok_s;
  logic              pop_s;
  logic              clr_ovf_s;
  logic              full_s;
  logic              empty_s;
  logic [WIDTH-1:0]  status_s;
  logic [WIDTH-1:0]  rdata_s;
  logic              unused_addr_s;

  assign mmio_sel_s    = bus.dmem_addr[DADDR-1];
  assign reg_sel_s     = mmio_reg_e'(bus.dmem_addr[3:2]);
  assign ram_idx_s     = bus.dmem_addr[RAM_AW+1:2];
  // Alias bits and the byte offset take no part in decode.
  assign unused_addr_s = ^{bus.dmem_addr[DADDR-2:RAM_AW+2], bus.dmem_addr[1:0]};

  assign full_s     = (count_r == FULL_COUNT);
  assign empty_s    = (count_r == ZERO_COUNT);
  assign pop_s      = !empty_s && bus.tx_ready;
  assign push_req_s = mmio_sel_s && (reg_sel_s == REG_TX_DATA) && bus.dmem_wr_en[0];
  // A push into a full FIFO still fits when the head leaves in the same cycle.
  assign push_ok_s  = push_req_s && (!full_s || pop_s);
  assign clr_ovf_s  = mmio_sel_s && (reg_sel_s == REG_STATUS) &&
                      bus.dmem_wr_en[2] && bus.dmem_wdata[16];

  // Byte-lane RAM writes; contents survive reset.
  always_ff @(posedge clk) begin
    if (!mmio_sel_s) begin
      for (int i = 0; i < 4; i++) begin
        if (bus.dmem_wr_en[i]) begin
          ram_r[ram_idx_s][8*i +: 8] <= bus.dmem_wdata[8*i +: 8];
        end
      end
    end
  end

  // FIFO storage; validity is tracked by the pointers, so no reset needed.
  always_ff @(posedge clk) begin
    if (push_ok_s) begin
      fifo_r[wr_ptr_r] <= bus.dmem_wdata[7:0];
    end
  end

  // Cycle counter, FIFO pointers/count and sticky overflow flag.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cycle_r    <= 64'd0;
      rd_ptr_r   <= {FIFO_AW{1'b0}};
      wr_ptr_r   <= {FIFO_AW{1'b0}};
      count_r    <= ZERO_COUNT;
      overflow_r <= 1'b0;
    end else begin
      cycle_r <= cycle_r + 64'd1;
      if (pop_s) begin
        rd_ptr_r <= rd_ptr_r + FIFO_AW'(1);
      end
      if (push_ok_s) begin
        wr_ptr_r <= wr_ptr_r + FIFO_AW'(1);
      end
      case ({push_ok_s, pop_s})
        2'b10:   count_r <= count_r + (FIFO_AW+1)'(1);
        2'b01:   count_r <= count_r - (FIFO_AW+1)'(1);
        default: count_r <= count_r;
      endcase
      if (push_req_s && !push_ok_s) begin
        overflow_r <= 1'b1;
      end else if (clr_ovf_s) begin
        overflow_r <= 1'b0;
      end
    end
  end

  // Asynchronous read mux: RAM word or MMIO register.
  always_comb begin
    status_s              = {WIDTH{1'b0}};
    status_s[FIFO_AW:0]   = count_r;
    status_s[8]           = full_s;
    status_s[9]           = empty_s;
    status_s[16]          = overflow_r;
    rdata_s               = {WIDTH{1'b0}};
    if (mmio_sel_s) begin
      case (reg_sel_s)
        REG_CYCLE_LO: rdata_s = cycle_r[31:0];
        REG_CYCLE_HI: rdata_s = cycle_r[63:32];
        REG_TX_DATA:  rdata_s = {WIDTH{1'b0}};
        REG_STATUS:   rdata_s = status_s;
        default:      rdata_s = {WIDTH{1'b0}};
      endcase
    end else begin
      rdata_s = ram_r[ram_idx_s];
    end
  end

  assign bus.dmem_rdata = rdata_s;
  assign bus.tx_valid   = !empty_s;
  assign bus.tx_data    = empty_s ? 8'h00 : fifo_r[rd_ptr_r];
endmodule

// File: doc/dmem_mmio.md
Name: dmem_mmio

Overview:
- Data-side memory subsystem on the core's dmem port.
- Consumes dmem_addr, dmem_wdata and dmem_wr_en[3:0]; returns dmem_rdata to the core's memory stage.
- Contains a byte-writable data RAM and a small MMIO window.
- MMIO window holds a 64-bit cycle counter and a byte TX FIFO drained through a valid/ready output stream.

Parameters:
- WIDTH, 32, data word width; only 32 supported.
- DADDR, 16, byte address width of dmem_addr.
- RAM_AW, 12, RAM word-address width; depth = 2**RAM_AW words.
- FIFO_AW, 3, TX FIFO pointer width; depth = 2**FIFO_AW entries.

Ports:
- clk  in  1  system clock, all state on rising edge.
- reset  in  1  asynchronous, active-high reset.
- dmem_addr  in  DADDR  byte address from core.
- dmem_wdata  in  WIDTH  store data, byte lanes aligned to address.
- dmem_wr_en  in  4  per-byte write enables; lane i = bits [8i+7:8i].
- dmem_rdata  out  WIDTH  read data, combinational from dmem_addr.
- tx_data  out  8  FIFO head byte.
- tx_valid  out  1  FIFO non-empty.
- tx_ready  in  1  consumer accepts head this cycle.

Behaviour:
- Decode: dmem_addr[DADDR-1]=0 selects RAM; =1 selects MMIO.
- dmem_addr[1:0] is ignored for decode; the core supplies lane-aligned data and enables.
- RAM word index = dmem_addr[RAM_AW+1:2]. Higher bits below bit DADDR-1 are ignored, so the RAM aliases.
- RAM write: on clk edge, byte lane i is written when dmem_wr_en[i]=1. Other lanes are unchanged.
- RAM read: asynchronous. Same-cycle read of an address being written returns the old data; new data is visible the next cycle.
- RAM contents are not reset.
- MMIO register select = dmem_addr[3:2]; dmem_addr[DADDR-2:4] is ignored (aliases).
- 0x0 CYCLE_LO, read-only: cycle[31:0].
- 0x4 CYCLE_HI, read-only: cycle[63:32].
- Cycle counter: 64-bit, increments every cycle out of reset, wraps from all-ones to 0. Writes to CYCLE_LO/CYCLE_HI are ignored.
- 0x8 TX_DATA: a write with dmem_wr_en[0]=1 pushes dmem_wdata[7:0]. Reads return 0.
- 0xC STATUS, read layout:
  - [FIFO_AW:0] = count.
  - [8] = full.
  - [9] = empty.
  - [16] = overflow.
  - All other bits read 0.
- STATUS write: dmem_wr_en[2]=1 with dmem_wdata[16]=1 clears overflow. Other STATUS writes are ignored.
- FIFO: circular buffer with rd/wr pointers of FIFO_AW bits that wrap modulo depth; count ranges 0..depth.
- tx_valid = (count != 0). tx_data = entry at rd pointer, valid while tx_valid=1.
- Pop on clk edge when tx_valid & tx_ready.
- Push accepted when count < depth, or when count == depth and a pop occurs in the same cycle.
- Push + pop in the same cycle: count unchanged, both pointers advance.
- Push when full with no pop: byte dropped, overflow set (sticky) until cleared via STATUS.
- tx_ready while empty: no effect.
- Reset values: cycle=0, pointers=0, count=0, overflow=0, tx_valid=0, tx_data=0. dmem_rdata follows the reset register values for MMIO reads.
- Reset asserted mid-operation empties the FIFO immediately (asynchronous) and discards its contents. RAM is unaffected.

Test Plan:
- Reset, then RAM writes: write 0xDEADBEEF to 0x0010 with wr_en=4'hF, then 0x000000AA with wr_en=4'h1 -> read 0x0010 returns 0xDEADBEAA. Read 0x4010 (alias, RAM_AW=12) also returns 0xDEADBEAA.
- Cycle counter: release reset; read 0x8000 five cycles later -> 5, CYCLE_HI=0. Force counter to 0xFFFFFFFF_FFFFFFFF -> next cycle CYCLE_LO=0 and CYCLE_HI=0.
- TX FIFO fill: tx_ready=0; push 0x41..0x48 (8 bytes) -> STATUS=0x108. Ninth push 0x49 -> dropped, STATUS=0x10108.
- Drain: tx_ready=1 -> tx_data sequence 0x41..0x48 over 8 cycles, then tx_valid=0 and STATUS=0x10200. Write 0x00010000 to 0x800C with wr_en=4'h4 -> STATUS=0x200.
- Full with simultaneous push/pop: FIFO full, tx_ready=1, push 0x55 -> accepted, count stays 8, no overflow. 0x55 emerges last.
- Reset mid-stream: 3 bytes queued, pulse reset asynchronously between edges -> tx_valid=0 immediately, STATUS=0x200, cycle=0. Previously written RAM word still reads back intact.
